// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer for one clock domain.
// The async pin reset is synchronised into clk_i, stretched, then NUM_CH
// active-low reset outputs are released one at a time at fixed intervals.
// A software reset request re-runs the stretch and release sequence.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low pin reset (only async input)
//   swrst_req_i  synchronous software reset request, level, active-high
//   ch_en_i      per-channel enable; 0 holds that channel in reset
//   rstn_o       per-channel active-low reset (async assert, sync release)
//   all_rel_o    high while every channel slot has been released (RUN)
//   busy_o       inverse of all_rel_o
//   cause_o      (only with RST_SEQ_CAUSE_EN) sticky last reset cause:
//                2'b01 pin reset, 2'b10 software reset
//
// Optional feature macro: RST_SEQ_CAUSE_EN adds cause_o.

module rst_seq_ctrl #(
    parameter int unsigned SYNC_STAGES = 4,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned STRETCH_CYC = 16,
    parameter int unsigned STEP_CYC    = 8,
    parameter int unsigned SWRST_MIN   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              swrst_req_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    output logic [NUM_CH-1:0] rstn_o,
    output logic              all_rel_o,
    output logic              busy_o
`ifdef RST_SEQ_CAUSE_EN
    ,
    output logic [1:0]        cause_o
`endif
);

    localparam int unsigned CNT_MAX_A = (STRETCH_CYC > STEP_CYC) ? STRETCH_CYC : STEP_CYC;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > SWRST_MIN) ? CNT_MAX_A : SWRST_MIN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LAST_IDX  = (NUM_CH > 1) ? (NUM_CH - 1) : 0;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN,
        ST_SWRST
    } state_e;

    // Synchroniser for the pin reset release.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
    logic [NUM_CH-1:0] rstn_q, rstn_d;
    logic              all_rel_q, all_rel_d;
    logic              busy_q, busy_d;
`ifdef RST_SEQ_CAUSE_EN
    logic [1:0]        cause_q, cause_d;
`endif

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_SYNC;
            cnt_q     <= '0;
            idx_q     <= '0;
            rstn_q    <= '0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef RST_SEQ_CAUSE_EN
            cause_q   <= 2'b01;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rstn_q    <= rstn_d;
            all_rel_q <= all_rel_d;
            busy_q    <= busy_d;
`ifdef RST_SEQ_CAUSE_EN
            cause_q   <= cause_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        idx_nxt = idx_q + IDX_W'(1);

        unique case (state_q)
            ST_SYNC: begin
                if (rst_sync) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end

            ST_STRETCH: begin
                if (swrst_req_i) begin
                    state_d = ST_SWRST;
                    cnt_d   = '0;
                    rstn_d  = '0;
                end else if (cnt_q == CNT_W'(STRETCH_CYC - 1)) begin
                    // Channel 0 is released on the edge that leaves STRETCH.
                    cnt_d     = '0;
                    idx_d     = '0;
                    rstn_d[0] = ch_en_i[0];
                    state_d   = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (swrst_req_i) begin
                    state_d = ST_SWRST;
                    cnt_d   = '0;
                    rstn_d  = '0;
                end else if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
                    // A disabled channel still consumes its slot.
                    cnt_d = '0;
                    idx_d = idx_nxt;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (idx_nxt == IDX_W'(i)) begin
                            rstn_d[i] = ch_en_i[i];
                        end
                    end
                    if (idx_nxt == IDX_W'(LAST_IDX)) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (swrst_req_i) begin
                    state_d = ST_SWRST;
                    cnt_d   = '0;
                    rstn_d  = '0;
                end else begin
                    rstn_d = ch_en_i;
                end
            end

            ST_SWRST: begin
                rstn_d = '0;
                // A held request keeps restarting the minimum-length window.
                if (swrst_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(SWRST_MIN - 1)) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
                idx_d   = '0;
                rstn_d  = '0;
            end
        endcase

        all_rel_d = (state_d == ST_RUN);
        busy_d    = ~all_rel_d;

`ifdef RST_SEQ_CAUSE_EN
        cause_d = cause_q;
        if ((state_d == ST_SWRST) && (state_q != ST_SWRST)) begin
            cause_d = 2'b10;
        end
`endif
    end

    assign rstn_o    = rstn_q;
    assign all_rel_o = all_rel_q;
    assign busy_o    = busy_q;
`ifdef RST_SEQ_CAUSE_EN
    assign cause_o   = cause_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed bench for rst_seq_ctrl.
// A timeline table of {inputs, expected outputs} checkpoints (edge numbers
// counted from the last pin-reset release) drives the default-parameter DUT;
// a hand-written sequence covers an async reset glitch mid-release and a
// second instance with SYNC_STAGES=2, NUM_CH=1, STRETCH_CYC=1.

module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       swrst;
    logic [3:0] ch_en;
    logic [3:0] rstn;
    logic       all_rel;
    logic       busy;

    logic       swrst1;
    logic [0:0] ch_en1;
    logic [0:0] rstn1;
    logic       all_rel1;
    logic       busy1;

`ifdef RST_SEQ_CAUSE_EN
    logic [1:0] cause;
    logic [1:0] cause1;
`endif

    rst_seq_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .swrst_req_i (swrst),
        .ch_en_i     (ch_en),
        .rstn_o      (rstn),
        .all_rel_o   (all_rel),
        .busy_o      (busy)
`ifdef RST_SEQ_CAUSE_EN
        ,
        .cause_o     (cause)
`endif
    );

    rst_seq_ctrl #(
        .SYNC_STAGES (2),
        .NUM_CH      (1),
        .STRETCH_CYC (1),
        .STEP_CYC    (8),
        .SWRST_MIN   (4)
    ) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .swrst_req_i (swrst1),
        .ch_en_i     (ch_en1),
        .rstn_o      (rstn1),
        .all_rel_o   (all_rel1),
        .busy_o      (busy1)
`ifdef RST_SEQ_CAUSE_EN
        ,
        .cause_o     (cause1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          pin_rst;
        int unsigned at_edge;
        logic        swrst;
        logic [3:0]  ch_en;
        logic [3:0]  exp_rstn;
        logic        exp_all;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t        vq[$];
    int unsigned edge_cnt;
    int unsigned n_vec;
    int unsigned n_err;

    function automatic void add(bit p, int unsigned e, logic s, logic [3:0] en,
                                logic [3:0] r, logic a, logic [1:0] c);
        vec_t v;
        v.pin_rst   = p;
        v.at_edge   = e;
        v.swrst     = s;
        v.ch_en     = en;
        v.exp_rstn  = r;
        v.exp_all   = a;
        v.exp_cause = c;
        vq.push_back(v);
    endfunction

    task automatic check(string nm, int unsigned idx, logic [3:0] got, logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s #%0d (edge %0d): got %h want %h", nm, idx, edge_cnt, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic pin_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        swrst    = 1'b0;
        ch_en    = 4'hF;
        swrst1   = 1'b0;
        ch_en1   = 1'b1;
        edge_cnt = 0;
        n_vec    = 0;
        n_err    = 0;

        // Power-up, all channels enabled: releases at 21/29/37/45.
        add(1,   0, 0, 4'hF, 4'h0, 0, 2'b01);
        add(0,  20, 0, 4'hF, 4'h0, 0, 2'b01);
        add(0,  21, 0, 4'hF, 4'h1, 0, 2'b01);
        add(0,  28, 0, 4'hF, 4'h1, 0, 2'b01);
        add(0,  29, 0, 4'hF, 4'h3, 0, 2'b01);
        add(0,  37, 0, 4'hF, 4'h7, 0, 2'b01);
        add(0,  44, 0, 4'hF, 4'h7, 0, 2'b01);
        add(0,  45, 0, 4'hF, 4'hF, 1, 2'b01);
        add(0,  50, 0, 4'hF, 4'hF, 1, 2'b01);
        // One-cycle software reset at edge 51: 4 SWRST + 16 STRETCH, release from 71.
        add(0,  51, 1, 4'hF, 4'h0, 0, 2'b10);
        add(0,  55, 0, 4'hF, 4'h0, 0, 2'b10);
        add(0,  70, 0, 4'hF, 4'h0, 0, 2'b10);
        add(0,  71, 0, 4'hF, 4'h1, 0, 2'b10);
        add(0,  79, 0, 4'hF, 4'h3, 0, 2'b10);
        add(0,  87, 0, 4'hF, 4'h7, 0, 2'b10);
        add(0,  94, 0, 4'hF, 4'h7, 0, 2'b10);
        add(0,  95, 0, 4'hF, 4'hF, 1, 2'b10);
        // Request held for edges 101..110; last sampled high at 110, ch0 at 130.
        add(0, 100, 0, 4'hF, 4'hF, 1, 2'b10);
        add(0, 105, 1, 4'hF, 4'h0, 0, 2'b10);
        add(0, 110, 1, 4'hF, 4'h0, 0, 2'b10);
        add(0, 129, 0, 4'hF, 4'h0, 0, 2'b10);
        add(0, 130, 0, 4'hF, 4'h1, 0, 2'b10);
        add(0, 138, 0, 4'hF, 4'h3, 0, 2'b10);
        add(0, 146, 0, 4'hF, 4'h7, 0, 2'b10);
        add(0, 154, 0, 4'hF, 4'hF, 1, 2'b10);
        // Channel 2 disabled through release, then enabled in RUN.
        add(1,   0, 0, 4'hB, 4'h0, 0, 2'b01);
        add(0,  21, 0, 4'hB, 4'h1, 0, 2'b01);
        add(0,  29, 0, 4'hB, 4'h3, 0, 2'b01);
        add(0,  37, 0, 4'hB, 4'h3, 0, 2'b01);
        add(0,  44, 0, 4'hB, 4'h3, 0, 2'b01);
        add(0,  45, 0, 4'hB, 4'hB, 1, 2'b01);
        add(0,  46, 0, 4'hF, 4'hF, 1, 2'b01);
        // Request ignored in SYNC; then taken in RELEASE (26) and STRETCH (35).
        add(1,   0, 0, 4'hF, 4'h0, 0, 2'b01);
        add(0,   4, 1, 4'hF, 4'h0, 0, 2'b01);
        add(0,  21, 0, 4'hF, 4'h1, 0, 2'b01);
        add(0,  25, 0, 4'hF, 4'h1, 0, 2'b01);
        add(0,  26, 1, 4'hF, 4'h0, 0, 2'b10);
        add(0,  34, 0, 4'hF, 4'h0, 0, 2'b10);
        add(0,  35, 1, 4'hF, 4'h0, 0, 2'b10);
        add(0,  54, 0, 4'hF, 4'h0, 0, 2'b10);
        add(0,  55, 0, 4'hF, 4'h1, 0, 2'b10);
        add(0,  63, 0, 4'hF, 4'h3, 0, 2'b10);

        foreach (vq[i]) begin
            if (vq[i].pin_rst) pin_reset();
            swrst = vq[i].swrst;
            ch_en = vq[i].ch_en;
            while (edge_cnt < vq[i].at_edge) tick();
            check("rstn", i, rstn, vq[i].exp_rstn);
            check("all_rel", i, {3'b000, all_rel}, {3'b000, vq[i].exp_all});
            check("busy", i, {3'b000, busy}, {3'b000, ~vq[i].exp_all});
`ifdef RST_SEQ_CAUSE_EN
            check("cause", i, {2'b00, cause}, {2'b00, vq[i].exp_cause});
`endif
        end

        // Short rst_ni glitch mid-RELEASE (ch0, ch1 out): outputs drop with no clock.
        swrst = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("glitch_rstn", 0, rstn, 4'h0);
        check("glitch_all_rel", 0, {3'b000, all_rel}, 4'h0);
        check("glitch_busy", 0, {3'b000, busy}, 4'h1);
`ifdef RST_SEQ_CAUSE_EN
        check("glitch_cause", 0, {2'b00, cause}, 4'h1);
`endif
        @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;
        check("dut1_rst_rstn", 0, {3'b000, rstn1}, 4'h0);
        check("dut1_rst_busy", 0, {3'b000, busy1}, 4'h1);
        while (edge_cnt < 3) tick();
        check("dut1_e3_rstn", 3, {3'b000, rstn1}, 4'h0);
        check("dut1_e3_all_rel", 3, {3'b000, all_rel1}, 4'h0);
        tick();
        check("dut1_e4_rstn", 4, {3'b000, rstn1}, 4'h1);
        check("dut1_e4_all_rel", 4, {3'b000, all_rel1}, 4'h1);
        check("dut1_e4_busy", 4, {3'b000, busy1}, 4'h0);
        while (edge_cnt < 20) tick();
        check("restart_e20_rstn", 20, rstn, 4'h0);
        tick();
        check("restart_e21_rstn", 21, rstn, 4'h1);
        while (edge_cnt < 29) tick();
        check("restart_e29_rstn", 29, rstn, 4'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
